// File: rtl/a_row_loader.sv
// a_row_loader: packs a serial element stream into DIM-wide rows and writes them to memA,
// one WrEn pulse per row, then pulses done after the last row.
module a_row_loader #(
   parameter int BITS_AB = 8,
   parameter int DIM     = 8,
   parameter int ROWBITS = $clog2(DIM)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic                             abort,
   input  logic                             in_valid,
   input  logic signed [BITS_AB-1:0]        in_data,
   output logic                             in_ready,
   output logic                             WrEn,
   output logic [ROWBITS-1:0]               Arow,
   output logic [DIM-1:0][BITS_AB-1:0]      Ain,
   output logic                             busy,
   output logic                             done
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FILL  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;
   localparam logic [ROWBITS-1:0] LAST = ROWBITS'(DIM - 1);

   logic [1:0]         state;
   logic [ROWBITS-1:0] col;
   logic [ROWBITS-1:0] row;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         col   <= '0;
         row   <= '0;
         Ain   <= '0;
      end else if (abort && state != IDLE) begin
         state <= IDLE;
         col   <= '0;
         row   <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state <= FILL;
               col   <= '0;
               row   <= '0;
            end
            FILL: if (in_valid) begin
               Ain[col] <= in_data;
               col      <= (col == LAST) ? '0 : col + 1'b1;
               state    <= (col == LAST) ? WRITE : FILL;
            end
            WRITE: begin
               state <= (row == LAST) ? DONE : FILL;
               row   <= (row == LAST) ? row : row + 1'b1;
            end
            default: begin
               state <= IDLE;
               row   <= '0;
            end
         endcase
      end
   end

   // Moore outputs: everything decodes from registered state
   assign in_ready = (state == FILL);
   assign WrEn     = (state == WRITE);
   assign Arow     = row;
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);
endmodule

// File: tb/tb_a_row_loader.sv
// tb_a_row_loader: directed loads with a scoreboard queue of expected row writes and done pulses,
// drained by a monitor that watches WrEn/done.
module tb_a_row_loader;
   logic clk = 0, rst = 1, start = 0, abort = 0, in_valid = 0;
   logic [7:0] in_data = '0;
   logic in_ready, WrEn, busy, done;
   logic [2:0] Arow;
   logic [7:0][7:0] Ain;

   a_row_loader #(.BITS_AB(8), .DIM(8), .ROWBITS(3)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .WrEn(WrEn), .Arow(Arow), .Ain(Ain),
      .busy(busy), .done(done));

   always #5 clk = ~clk;

   typedef struct {
      bit         is_done;
      logic [2:0] row;
      logic [63:0] data;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int n_cmp = 0, n_err = 0, cyc = 0, t0 = 0;
   logic [7:0] mv [64];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // Monitor: every WrEn or done cycle must match the head of the queue
   always @(negedge clk) begin
      if (WrEn || done) begin
         if (WrEn) chk("wren_vs_ready", {63'd0, in_ready}, 64'd0);
         if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event: WrEn=%b done=%b Arow=%0d expected none", WrEn, done, Arow);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("event_kind", {62'd0, WrEn, done}, {62'd0, !e.is_done, e.is_done});
            if (!e.is_done) begin
               chk("arow", {61'd0, Arow}, {61'd0, e.row});
               chk("ain", Ain, e.data);
            end
            if (e.cyc >= 0) chk("timing", 64'(cyc - t0), 64'(e.cyc));
         end
      end
   end

   task automatic check_zero(input string nm);
      chk({nm, "_ctrl"}, {58'd0, in_ready, WrEn, Arow, busy, done}, 64'd0);
      chk({nm, "_ain"}, Ain, 64'd0);
   endtask

   task automatic do_start();
      start = 1;
      @(negedge clk);
      start = 0;
      t0 = cyc - 1;
   endtask

   task automatic send(input logic [7:0] v);
      int n = 0;
      in_valid = 1;
      in_data  = v;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL handshake_timeout: in_ready=%b expected 1", in_ready);
      end
      @(negedge clk);
   endtask

   task automatic load(input bit gap, input int start_at, input int abort_at, input int rst_row, input bit timed);
      do_start();
      for (int i = 0; i < 64; i++) begin
         int r = i / 8, c = i % 8;
         if (c == 0 && (abort_at < 0 || abort_at >= i + 8) && (rst_row < 0 || r <= rst_row)) begin
            exp_t e;
            logic [63:0] d;
            for (int k = 0; k < 8; k++) d[k*8 +: 8] = mv[i + k];
            e.is_done = 0; e.row = 3'(r); e.data = d; e.cyc = timed ? 9 * (r + 1) : -1;
            q.push_back(e);
            if (r == 7 && abort_at < 0 && rst_row < 0) begin
               e.is_done = 1; e.cyc = timed ? 73 : -1;
               q.push_back(e);
            end
         end
         if (i == abort_at) begin
            in_valid = 1;
            in_data  = mv[i];
            abort    = 1;
            @(negedge clk);
            abort    = 0;
            in_valid = 0;
            return;
         end
         if (i == start_at) start = 1;
         send(mv[i]);
         start = 0;
         if (rst_row == r && c == 7) begin
            in_valid = 0;
            rst = 1;
            @(negedge clk);
            rst = 0;
            return;
         end
         if (gap) begin
            in_valid = 0;
            @(negedge clk);
         end
      end
      in_valid = 0;
      repeat (2) @(negedge clk);
      chk("busy_after_done", {62'd0, busy, done}, 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check_zero("reset_init");
      rst = 0;
      @(negedge clk);
      // reset mid-stream, after a few beats of row 0
      do_start();
      for (int i = 0; i < 5; i++) send(8'(i + 1));
      rst = 1;
      repeat (2) @(negedge clk);
      in_valid = 0;
      check_zero("reset_mid");
      rst = 0;
      @(negedge clk);
      chk("idle_after_reset", {62'd0, in_ready, busy}, 64'd0);
      // full load, valid held high, cycle-exact
      for (int i = 0; i < 64; i++) mv[i] = 8'(i);
      load(0, -1, -1, -1, 1);
      // same data with gaps
      load(1, -1, -1, -1, 0);
      // in_valid in IDLE is ignored and Ain holds the last row
      in_valid = 1;
      in_data  = 8'h55;
      repeat (3) @(negedge clk);
      chk("idle_no_ready", {62'd0, in_ready, busy}, 64'd0);
      chk("idle_ain_hold", Ain, 64'h3f3e3d3c3b3a3938);
      in_valid = 0;
      @(negedge clk);
      // start pulse during row 2 does not restart
      load(0, 20, -1, -1, 0);
      // extremes in every row, abort on beat 4 of row 3
      for (int i = 0; i < 64; i++) mv[i] = (i % 8 == 0) ? 8'h80 : (i % 8 == 7) ? 8'h7f : 8'(i * 3);
      load(0, -1, 28, -1, 0);
      @(negedge clk);
      chk("abort_idle", {61'd0, in_ready, busy, done}, 64'd0);
      load(0, -1, -1, -1, 0);
      // reset while row 5 is being written
      load(0, -1, -1, 5, 0);
      check_zero("reset_write");
      load(1, -1, -1, -1, 0);
      repeat (3) @(negedge clk);
      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
